// File: rtl/rom_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader_ctrl
// Brief    : Serial-to-ROM download controller. Receives a little-endian
//            32-bit word count, N little-endian data words and an 8-bit
//            additive checksum. Each word is written to instruction ROM, and
//            the core is held off the ROM while the session is running.
// Revision : 1.0  initial release
// ============================================================================
module rom_loader_ctrl #(
  parameter int unsigned ROM_DEPTH      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        rom_wr_en_o,
  output logic [31:0] rom_wr_addr_o,
  output logic [31:0] rom_wr_data_o,
  output logic        hold_o,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [31:0] c_depth    = 32'(ROM_DEPTH);
  localparam logic [31:0] c_tmo_last = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  c_err_none = 2'd0;
  localparam logic [1:0]  c_err_len  = 2'd1;
  localparam logic [1:0]  c_err_csum = 2'd2;
  localparam logic [1:0]  c_err_tmo  = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] len_q, len_d;          // header word count N
  logic [31:0] idx_q, idx_d;          // current word index k
  logic [31:0] word_q, word_d;        // word being assembled
  logic [31:0] tmr_q, tmr_d;          // idle cycles since last accepted byte
  logic [1:0]  bcnt_q, bcnt_d;        // byte position within header/word
  logic [7:0]  csum_q, csum_d;        // running payload checksum
  logic [1:0]  err_code_q, err_code_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        rx_ready_q, rx_ready_d;
  logic        wr_en_q, wr_en_d;
  logic        active_q, active_d;    // drives both hold_o and busy_o
  logic        done_q, done_d;        // drives both done_o and cpu_rst_o
  logic        err_q, err_d;

  logic        w_rx_take;
  logic        w_waiting;
  logic        w_timeout;
  logic [31:0] w_len_next;
  logic [31:0] w_word_next;

  // rx_ready_q tracks state_q, so a byte is consumed only in a receiving state
  assign w_rx_take   = rx_valid_i && rx_ready_q;
  assign w_waiting   = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign w_timeout   = w_waiting && !w_rx_take && (tmr_q >= c_tmo_last);
  // Little-endian assembly: each new byte enters at the top and shifts down
  assign w_len_next  = {rx_data_i, len_q[31:8]};
  assign w_word_next = {rx_data_i, word_q[31:8]};

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    bcnt_d     = bcnt_q;
    err_code_d = err_code_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    tmr_d      = w_waiting ? (w_rx_take ? 32'd0 : tmr_q + 32'd1) : 32'd0;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start_i) begin
          state_d    = S_HDR;
          idx_d      = 32'd0;
          bcnt_d     = 2'd0;
          csum_d     = 8'd0;
          err_code_d = c_err_none;
        end
      end
      S_HDR: begin
        if (w_timeout) begin
          state_d    = S_ERR;
          err_code_d = c_err_tmo;
        end else if (w_rx_take) begin
          len_d  = w_len_next;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if ((w_len_next == 32'd0) || (w_len_next > c_depth)) begin
              state_d    = S_ERR;
              err_code_d = c_err_len;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (w_timeout) begin
          state_d    = S_ERR;
          err_code_d = c_err_tmo;
        end else if (w_rx_take) begin
          word_d = w_word_next;
          csum_d = csum_q + rx_data_i;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d   = S_WRITE;
            wr_addr_d = {idx_q[29:0], 2'b00};
            wr_data_d = w_word_next;
          end
        end
      end
      S_WRITE: begin
        if (idx_q == (len_q - 32'd1)) begin
          state_d = S_CSUM;
        end else begin
          idx_d   = idx_q + 32'd1;
          state_d = S_DATA;
        end
      end
      S_CSUM: begin
        if (w_timeout) begin
          state_d    = S_ERR;
          err_code_d = c_err_tmo;
        end else if (w_rx_take) begin
          if (rx_data_i == csum_q) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_ERR;
            err_code_d = c_err_csum;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are a function of the next state so they line up with state_q
    rx_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
    wr_en_d    = (state_d == S_WRITE);
    active_d   = (state_d != S_IDLE) && (state_d != S_ERR);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  // State and output registers; reset aborts the session immediately
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      len_q      <= 32'd0;
      idx_q      <= 32'd0;
      word_q     <= 32'd0;
      tmr_q      <= 32'd0;
      bcnt_q     <= 2'd0;
      csum_q     <= 8'd0;
      err_code_q <= c_err_none;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 32'd0;
      rx_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      tmr_q      <= tmr_d;
      bcnt_q     <= bcnt_d;
      csum_q     <= csum_d;
      err_code_q <= err_code_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rx_ready_q <= rx_ready_d;
      wr_en_q    <= wr_en_d;
      active_q   <= active_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rx_ready_o    = rx_ready_q;
  assign rom_wr_en_o   = wr_en_q;
  assign rom_wr_addr_o = wr_addr_q;
  assign rom_wr_data_o = wr_data_q;
  assign hold_o        = active_q;
  assign busy_o        = active_q;
  assign done_o        = done_q;
  assign cpu_rst_o     = done_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_loader_ctrl
// Brief    : Scoreboard bench for rom_loader_ctrl. Each session's expected
//            ROM writes / done pulse / error entry are queued from the
//            protocol rules; a monitor pops and compares as the DUT emits.
// Revision : 1.0  initial release
// ============================================================================
module tb_rom_loader_ctrl;

  localparam int TB_DEPTH = 8;
  localparam int TB_TMO   = 16;

  localparam int M_OK       = 0;
  localparam int M_BADCS    = 1;
  localparam int M_TMO      = 2;
  localparam int M_RST      = 3;
  localparam int M_STARTMID = 4;
  localparam int M_BADLEN   = 5;

  localparam logic [3:0] EV_WR   = 4'd1;
  localparam logic [3:0] EV_DONE = 4'd2;
  localparam logic [3:0] EV_ERR  = 4'd3;

  typedef struct packed {
    logic [3:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        rom_wr_en_o;
  logic [31:0] rom_wr_addr_o;
  logic [31:0] rom_wr_data_o;
  logic        hold_o;
  logic        cpu_rst_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [72:0] all_out;

  int          total = 0;
  int          bad   = 0;
  int          gap_max = 0;
  ev_t         exp_q[$];
  logic [31:0] words [0:TB_DEPTH-1];

  rom_loader_ctrl #(
    .ROM_DEPTH      (TB_DEPTH),
    .TIMEOUT_CYCLES (TB_TMO)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_i       (start_i),
    .rx_valid_i    (rx_valid_i),
    .rx_data_i     (rx_data_i),
    .rx_ready_o    (rx_ready_o),
    .rom_wr_en_o   (rom_wr_en_o),
    .rom_wr_addr_o (rom_wr_addr_o),
    .rom_wr_data_o (rom_wr_data_o),
    .hold_o        (hold_o),
    .cpu_rst_o     (cpu_rst_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .err_code_o    (err_code_o)
  );

  assign all_out = {rx_ready_o, rom_wr_en_o, rom_wr_addr_o, rom_wr_data_o,
                    hold_o, cpu_rst_o, busy_o, done_o, err_o, err_code_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push_ev(input logic [3:0] k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  // Monitor: turns DUT output activity into events and compares with the queue
  initial begin : monitor
    ev_t  e;
    ev_t  a;
    logic prev_done;
    logic prev_err;
    prev_done = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0;
        prev_err  = 1'b0;
      end else begin
        if (prev_done)
          chk("done_single_cycle", {done_o, cpu_rst_o, hold_o, busy_o}, 0);
        a = '0;
        if (rom_wr_en_o) begin
          a.kind = EV_WR;
          a.addr = rom_wr_addr_o;
          a.data = rom_wr_data_o;
        end else if (done_o || cpu_rst_o) begin
          a.kind = EV_DONE;
          a.data = {29'b0, hold_o, done_o, cpu_rst_o};
        end else if (err_o && !prev_err) begin
          a.kind = EV_ERR;
          a.data = {30'b0, err_code_o};
        end
        if (a.kind != 4'd0) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event actual=%0h required=none", a);
          end else begin
            e = exp_q.pop_front();
            chk("event", a, e);
          end
        end
        prev_done = done_o;
        prev_err  = err_o;
      end
    end
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Present one byte and hold it until taken; reports cycles spent not-ready
  task automatic send_byte(input logic [7:0] b, output int waited);
    waited     = 0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(negedge clk);
    while (!rx_ready_o && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 40) begin
      total++;
      bad++;
      $display("FAIL rx_accept actual=never_ready required=ready");
    end
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
    start_i    = 1'b0;
  endtask

  // One download session; expected events come from the protocol rules
  task automatic run_load(input logic [31:0] n, input int mode, input int stop_at, input logic [7:0] cs_xor);
    int         nb;
    int         waited;
    int         gap;
    bit         word_end;
    logic [7:0] csum;
    logic [1:0] exp_err;

    nb   = (mode == M_TMO || mode == M_RST) ? stop_at : int'(n) * 4;
    csum = 8'd0;
    if (mode == M_BADLEN) begin
      exp_err = 2'd1;
      push_ev(EV_ERR, 32'd0, 32'd1);
    end else begin
      for (int k = 0; k < int'(n); k++)
        for (int j = 0; j < 4; j++)
          csum = csum + words[k][8*j +: 8];
      for (int k = 0; k < nb / 4; k++)
        push_ev(EV_WR, 32'(k * 4), words[k]);
      case (mode)
        M_BADCS: begin exp_err = 2'd2; push_ev(EV_ERR, 32'd0, 32'd2); end
        M_TMO:   begin exp_err = 2'd3; push_ev(EV_ERR, 32'd0, 32'd3); end
        M_RST:   exp_err = 2'd0;
        default: begin exp_err = 2'd0; push_ev(EV_DONE, 32'd0, 32'd7); end
      endcase
    end

    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(n[8*i +: 8], waited);
      chk("hdr_wait", 96'(waited), 0);
    end

    word_end = 1'b0;
    if (mode != M_BADLEN) begin
      for (int i = 0; i < nb; i++) begin
        gap = $urandom_range(0, gap_max);
        repeat (gap) begin @(posedge clk); #1; end
        if (mode == M_STARTMID && i == 2) start_i = 1'b1;
        send_byte(words[i/4][8*(i%4) +: 8], waited);
        chk("data_wait", 96'(waited), (gap == 0 && word_end) ? 1 : 0);
        word_end = (i % 4 == 3);
      end
      if (mode == M_OK || mode == M_STARTMID || mode == M_BADCS) begin
        gap = $urandom_range(0, gap_max);
        repeat (gap) begin @(posedge clk); #1; end
        send_byte(csum ^ cs_xor, waited);
        chk("csum_wait", 96'(waited), (gap == 0) ? 1 : 0);
      end
    end

    if (mode == M_RST) begin
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", 96'(all_out), 0);
      chk("writes_before_reset", 96'(exp_q.size()), 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
    end else begin
      for (int c = 0; c < TB_TMO + 40 && exp_q.size() != 0; c++) begin
        @(posedge clk); #1;
      end
      chk("scoreboard_drained", 96'(exp_q.size()), 0);
      exp_q.delete();
      repeat (2) begin @(posedge clk); #1; end
      chk("end_state", {busy_o, hold_o, done_o, rx_ready_o, err_o, err_code_o},
          {4'b0, exp_err != 2'd0, exp_err});
    end
  endtask

  initial begin : stim
    rst_n      = 1'b0;
    start_i    = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 96'(all_out), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Bytes offered while idle must be ignored
    rx_valid_i = 1'b1;
    rx_data_i  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      chk("idle_not_ready", 96'(rx_ready_o), 0);
    end
    @(posedge clk); #1;
    rx_valid_i = 1'b0;

    // Reference load; checksum byte = 0x13 + 0x93 + 0x10 = 0xB6.
    // Back-to-back bytes keep rx_valid high across each WRITE cycle.
    gap_max  = 0;
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    run_load(32'd2, M_OK, 0, 8'h00);

    run_load(32'd0, M_BADLEN, 0, 8'h00);
    run_load(32'(TB_DEPTH + 1), M_BADLEN, 0, 8'h00);
    run_load(32'hFFFF_FFFF, M_BADLEN, 0, 8'h00);

    words[0] = $urandom;
    run_load(32'd1, M_BADCS, 0, 8'h01);

    for (int k = 0; k < TB_DEPTH; k++) words[k] = $urandom;
    run_load(32'd3, M_TMO, 2, 8'h00);
    run_load(32'(TB_DEPTH), M_OK, 0, 8'h00);
    run_load(32'd2, M_STARTMID, 0, 8'h00);
    run_load(32'd3, M_RST, 6, 8'h00);
    words[0] = $urandom;
    run_load(32'd1, M_OK, 0, 8'h00);

    gap_max = 2;
    for (int s = 0; s < 24; s++) begin
      int          m;
      logic [31:0] n;
      n = 32'($urandom_range(1, TB_DEPTH));
      for (int k = 0; k < TB_DEPTH; k++) words[k] = $urandom;
      m = $urandom_range(0, 5);
      case (m)
        0, 1: run_load(n, M_OK, 0, 8'h00);
        2:    run_load(n, M_BADCS, 0, 8'($urandom_range(1, 255)));
        3:    run_load(n, M_STARTMID, 0, 8'h00);
        4:    run_load(n, M_TMO, $urandom_range(0, int'(n) * 4), 8'h00);
        default: begin
          n = ($urandom_range(0, 1) == 0) ? 32'(TB_DEPTH + 1 + $urandom_range(0, 1000))
                                          : ($urandom | 32'h8000_0000);
          run_load(n, M_BADLEN, 0, 8'h00);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
